// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Entry dst is stored at SB_ADDR_MAX bits; narrower register addresses are zero-extended.
package hazard_scoreboard_pkg;

  localparam int SB_ADDR_MAX = 8;
  localparam int IDX_W       = 2;
  localparam int FWD_W       = 3;

  localparam logic [2:0] DEF_JR_OPCODE = 3'b111;
  localparam logic [2:0] DEF_LD_OPCODE = 3'b010;

  localparam logic [FWD_W-1:0] FWD_REGFILE = 3'd0;

  typedef struct packed {
    logic                   valid;
    logic                   is_load;
    logic [SB_ADDR_MAX-1:0] dst;
  } sb_entry_t;

  // Tracked stage k is reported as k+1 so that 0 can mean "register file".
  function automatic logic [FWD_W-1:0] fwd_from_stage(input logic [IDX_W-1:0] idx);
    return FWD_W'(idx) + 3'd1;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one decode source against every tracked writer and reports
// the per-entry match vector plus the index of the youngest match.
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                              issue_valid,
  input  logic                              src_used,
  input  logic [SB_ADDR_MAX-1:0]            src,
  input  logic [DEPTH-1:0]                  entry_valid,
  input  logic [DEPTH-1:0][SB_ADDR_MAX-1:0] entry_dst,
  output logic [DEPTH-1:0]                  match,
  output logic [IDX_W-1:0]                  youngest
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign match[gi] = issue_valid & src_used & entry_valid[gi] & (entry_dst[gi] == src);
  end

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    youngest = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) youngest = IDX_W'(k);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight writers, raises load-use and
// jump-register stalls, selects forwarding sources and counts stall cycles.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int              ADDR_W    = 4,
  parameter int              OP_W      = 3,
  parameter int              DEPTH     = 2,
  parameter logic [OP_W-1:0] JR_OPCODE = {OP_W{1'b1}},
  parameter logic [OP_W-1:0] LD_OPCODE = OP_W'(DEF_LD_OPCODE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_opcode,
  input  logic [ADDR_W-1:0] issue_src1,
  input  logic [ADDR_W-1:0] issue_src2,
  input  logic              issue_src1_used,
  input  logic              issue_src2_used,
  input  logic              issue_wr_en,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              flush,
  output logic              stall,
  output logic [2:0]        fwd_sel1,
  output logic [2:0]        fwd_sel2,
  output logic [15:0]       stall_cycles
);

  sb_entry_t [DEPTH-1:0]              entries_reg;
  sb_entry_t [DEPTH-1:0]              entries_next;
  sb_entry_t                          new_entry;
  logic [15:0]                        stall_count_reg;
  logic [DEPTH-1:0]                   entry_valid;
  logic [DEPTH-1:0][SB_ADDR_MAX-1:0]  entry_dst;
  logic [SB_ADDR_MAX-1:0]             src1_ext;
  logic [SB_ADDR_MAX-1:0]             src2_ext;
  logic [DEPTH-1:0]                   match1;
  logic [DEPTH-1:0]                   match2;
  logic [IDX_W-1:0]                   young1;
  logic [IDX_W-1:0]                   young2;
  logic                               run;
  logic                               load_use;
  logic                               jr_hazard;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unpack
    assign entry_valid[gi] = entries_reg[gi].valid;
    assign entry_dst[gi]   = entries_reg[gi].dst;
  end

  assign src1_ext = SB_ADDR_MAX'(issue_src1);
  assign src2_ext = SB_ADDR_MAX'(issue_src2);

  hazard_match #(.DEPTH(DEPTH)) u_match1 (
    .issue_valid (issue_valid),
    .src_used    (issue_src1_used),
    .src         (src1_ext),
    .entry_valid (entry_valid),
    .entry_dst   (entry_dst),
    .match       (match1),
    .youngest    (young1)
  );

  hazard_match #(.DEPTH(DEPTH)) u_match2 (
    .issue_valid (issue_valid),
    .src_used    (issue_src2_used),
    .src         (src2_ext),
    .entry_valid (entry_valid),
    .entry_dst   (entry_dst),
    .match       (match2),
    .youngest    (young2)
  );

  // Reset and flush both silence every hazard output in the same cycle.
  assign run       = reset & ~flush;
  assign load_use  = (match1[0] | match2[0]) & entries_reg[0].is_load;
  assign jr_hazard = (issue_opcode == JR_OPCODE) & (|match2);
  assign stall     = run & (load_use | jr_hazard);

  assign fwd_sel1 = (run & ~stall & (|match1)) ? fwd_from_stage(young1) : FWD_REGFILE;
  assign fwd_sel2 = (run & ~stall & (|match2)) ? fwd_from_stage(young2) : FWD_REGFILE;

  always_comb begin
    new_entry.valid   = issue_valid & issue_wr_en & ~stall;
    new_entry.is_load = (issue_opcode == LD_OPCODE);
    new_entry.dst     = SB_ADDR_MAX'(issue_dst);
  end

  // Age every entry by one slot; the oldest falls off the end.
  always_comb begin
    entries_next    = entries_reg << $bits(sb_entry_t);
    entries_next[0] = new_entry;
    if (flush) entries_next = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      entries_reg     <= '0;
      stall_count_reg <= '0;
    end else begin
      entries_reg <= entries_next;
      if (stall && stall_count_reg != 16'hFFFF) stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_count_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table on the default build, then
// random traffic and stall-counter saturation on default and DEPTH=4/ADDR_W=5 builds.
module tb_hazard_scoreboard;

  localparam bit [2:0] OP_ADD = 3'd0;
  localparam bit [2:0] OP_LD  = 3'd2;
  localparam bit [2:0] OP_JR  = 3'd7;

  typedef struct {
    bit       rst_n;
    bit       valid;
    bit [2:0] op;
    bit [3:0] s1;
    bit       u1;
    bit [3:0] s2;
    bit       u2;
    bit       wr;
    bit [3:0] dst;
    bit       flush;
    bit       exp_stall;
    int       exp_f1;
    int       exp_f2;
    int       exp_cnt;
  } vec_t;

  typedef struct {
    int n;
    bit v[4];
    int d[4];
    bit ld[4];
    int cnt;
  } model_t;

  logic clock;
  int   checks = 0;
  int   errors = 0;

  logic       rst_a, valid_a, u1_a, u2_a, wr_a, flush_a, stall_a;
  logic [2:0] op_a, f1_a, f2_a;
  logic [3:0] src1_a, src2_a, dst_a;
  logic [15:0] cnt_a;

  logic       rst_b, valid_b, u1_b, u2_b, wr_b, flush_b, stall_b;
  logic [2:0] op_b, f1_b, f2_b;
  logic [4:0] src1_b, src2_b, dst_b;
  logic [15:0] cnt_b;

  hazard_scoreboard dut_a (
    .clock(clock), .reset(rst_a), .issue_valid(valid_a), .issue_opcode(op_a),
    .issue_src1(src1_a), .issue_src2(src2_a), .issue_src1_used(u1_a), .issue_src2_used(u2_a),
    .issue_wr_en(wr_a), .issue_dst(dst_a), .flush(flush_a),
    .stall(stall_a), .fwd_sel1(f1_a), .fwd_sel2(f2_a), .stall_cycles(cnt_a)
  );

  hazard_scoreboard #(.ADDR_W(5), .DEPTH(4)) dut_b (
    .clock(clock), .reset(rst_b), .issue_valid(valid_b), .issue_opcode(op_b),
    .issue_src1(src1_b), .issue_src2(src2_b), .issue_src1_used(u1_b), .issue_src2_used(u2_b),
    .issue_wr_en(wr_b), .issue_dst(dst_b), .flush(flush_b),
    .stall(stall_b), .fwd_sel1(f1_b), .fwd_sel2(f2_b), .stall_cycles(cnt_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(input bit rst_n, input bit valid, input bit [2:0] op,
                              input bit [3:0] s1, input bit u1, input bit [3:0] s2, input bit u2,
                              input bit wr, input bit [3:0] dst, input bit flush,
                              input bit es, input int ef1, input int ef2, input int ecnt);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.op = op; v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2;
    v.wr = wr; v.dst = dst; v.flush = flush;
    v.exp_stall = es; v.exp_f1 = ef1; v.exp_f2 = ef2; v.exp_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t s);
    rst_a = s.rst_n; valid_a = s.valid; op_a = s.op; src1_a = s.s1; u1_a = s.u1;
    src2_a = s.s2; u2_a = s.u2; wr_a = s.wr; dst_a = s.dst; flush_a = s.flush;
  endtask

  task automatic drive_b(input vec_t s);
    rst_b = s.rst_n; valid_b = s.valid; op_b = s.op; src1_b = {1'b0, s.s1}; u1_b = s.u1;
    src2_b = {1'b0, s.s2}; u2_b = s.u2; wr_b = s.wr; dst_b = {1'b0, s.dst}; flush_b = s.flush;
  endtask

  // Reference: in-flight writers listed youngest first; hazards derived from the rules directly.
  function automatic void predict(input model_t m, input vec_t s,
                                  output bit st, output int f1, output int f2);
    int y1 = -1;
    int y2 = -1;
    bit lu, jr;
    for (int k = 0; k < m.n; k++) begin
      if (s.valid && m.v[k]) begin
        if (y1 < 0 && s.u1 && m.d[k] == int'(s.s1)) y1 = k;
        if (y2 < 0 && s.u2 && m.d[k] == int'(s.s2)) y2 = k;
      end
    end
    lu = m.ld[0] && (y1 == 0 || y2 == 0);
    jr = (s.op == OP_JR) && (y2 >= 0);
    st = s.rst_n && !s.flush && (lu || jr);
    f1 = (!s.rst_n || s.flush || st || y1 < 0) ? 0 : y1 + 1;
    f2 = (!s.rst_n || s.flush || st || y2 < 0) ? 0 : y2 + 1;
  endfunction

  function automatic model_t advance(input model_t m, input vec_t s, input bit st);
    model_t r = m;
    if (!s.rst_n || s.flush) begin
      for (int k = 0; k < 4; k++) r.v[k] = 1'b0;
    end else begin
      for (int k = r.n - 1; k > 0; k--) begin
        r.v[k] = m.v[k-1]; r.d[k] = m.d[k-1]; r.ld[k] = m.ld[k-1];
      end
      r.v[0]  = s.valid && s.wr && !st;
      r.d[0]  = int'(s.dst);
      r.ld[0] = (s.op == OP_LD);
    end
    if (!s.rst_n) r.cnt = 0;
    else if (st && r.cnt < 65535) r.cnt++;
    return r;
  endfunction

  function automatic vec_t rand_vec(input bit force_rst);
    vec_t v;
    v.rst_n = !force_rst && ($urandom_range(0, 49) != 0);
    v.valid = ($urandom_range(0, 5) != 0);
    case ($urandom_range(0, 3))
      0:       v.op = OP_LD;
      1:       v.op = OP_JR;
      default: v.op = 3'($urandom_range(0, 7));
    endcase
    v.s1 = 4'($urandom_range(0, 3)); v.u1 = ($urandom_range(0, 3) != 0);
    v.s2 = 4'($urandom_range(0, 3)); v.u2 = ($urandom_range(0, 3) != 0);
    v.wr = ($urandom_range(0, 3) != 0); v.dst = 4'($urandom_range(0, 3));
    v.flush = ($urandom_range(0, 19) == 0);
    v.exp_stall = 1'b0; v.exp_f1 = 0; v.exp_f2 = 0; v.exp_cnt = 0;
    return v;
  endfunction

  vec_t   tbl[32];
  model_t ma, mb;

  initial begin
    vec_t s, idle_rst;
    bit   st_a, st_b;
    int   pf1, pf2, qf1, qf2;
    int   sat_cycles;
    bit   seen_34, seen_35;

    tbl[0]  = mk(0,1,OP_LD, 0,0,0,0,1,3,0, 0,0,0,0);
    tbl[1]  = mk(0,0,OP_ADD,0,0,0,0,0,0,0, 0,0,0,0);
    tbl[2]  = mk(1,0,OP_ADD,0,0,0,0,0,0,0, 0,0,0,0);
    tbl[3]  = mk(1,1,OP_ADD,0,0,0,0,1,5,0, 0,0,0,0);
    tbl[4]  = mk(1,1,OP_ADD,5,1,0,0,0,0,0, 0,1,0,0);
    tbl[5]  = mk(1,1,OP_ADD,0,0,0,0,1,6,0, 0,0,0,0);
    tbl[6]  = mk(1,0,OP_ADD,0,0,0,0,0,0,0, 0,0,0,0);
    tbl[7]  = mk(1,1,OP_ADD,6,1,0,0,0,0,0, 0,2,0,0);
    tbl[8]  = mk(1,1,OP_ADD,0,0,0,0,1,9,0, 0,0,0,0);
    tbl[9]  = mk(1,1,OP_ADD,9,1,0,0,1,9,0, 0,1,0,0);
    tbl[10] = mk(1,1,OP_ADD,9,1,9,1,0,0,0, 0,1,1,0);
    tbl[11] = mk(1,1,OP_LD, 0,0,0,0,1,3,0, 0,0,0,0);
    tbl[12] = mk(1,1,OP_ADD,0,0,3,1,1,4,0, 1,0,0,1);
    tbl[13] = mk(1,1,OP_ADD,0,0,3,1,1,4,0, 0,0,2,1);
    tbl[14] = mk(1,0,OP_ADD,0,0,0,0,0,0,0, 0,0,0,1);
    tbl[15] = mk(1,0,OP_ADD,0,0,0,0,0,0,0, 0,0,0,1);
    tbl[16] = mk(1,1,OP_ADD,0,0,0,0,1,7,0, 0,0,0,1);
    tbl[17] = mk(1,1,OP_JR, 0,0,7,1,0,0,0, 1,0,0,2);
    tbl[18] = mk(1,1,OP_JR, 0,0,7,1,0,0,0, 1,0,0,3);
    tbl[19] = mk(1,1,OP_JR, 0,0,7,1,0,0,0, 0,0,0,3);
    tbl[20] = mk(1,1,OP_LD, 0,0,0,0,1,3,0, 0,0,0,3);
    tbl[21] = mk(1,1,OP_ADD,0,0,3,1,0,0,1, 0,0,0,3);
    tbl[22] = mk(1,1,OP_ADD,0,0,3,1,0,0,0, 0,0,0,3);
    tbl[23] = mk(1,1,OP_LD, 0,0,0,0,1,3,0, 0,0,0,3);
    tbl[24] = mk(1,1,OP_ADD,0,0,3,1,0,0,0, 1,0,0,4);
    tbl[25] = mk(0,1,OP_ADD,0,0,3,1,0,0,0, 0,0,0,0);
    tbl[26] = mk(1,1,OP_ADD,0,0,3,1,0,0,0, 0,0,0,0);
    tbl[27] = mk(1,1,OP_LD, 0,0,0,0,1,2,0, 0,0,0,0);
    tbl[28] = mk(1,1,OP_ADD,2,0,0,0,0,0,0, 0,0,0,0);
    tbl[29] = mk(1,1,OP_LD, 0,0,0,0,1,1,0, 0,0,0,0);
    tbl[30] = mk(1,0,OP_JR, 1,1,1,1,0,0,0, 0,0,0,0);
    tbl[31] = mk(1,1,OP_JR, 1,1,0,0,0,0,0, 0,2,0,0);

    idle_rst = mk(0,0,OP_ADD,0,0,0,0,0,0,0, 0,0,0,0);
    drive_b(idle_rst);

    for (int i = 0; i < 32; i++) begin
      drive_a(tbl[i]);
      #2;
      chk($sformatf("vec%0d_stall", i), 32'(stall_a), 32'(tbl[i].exp_stall));
      chk($sformatf("vec%0d_fwd1", i), 32'(f1_a), 32'(tbl[i].exp_f1));
      chk($sformatf("vec%0d_fwd2", i), 32'(f2_a), 32'(tbl[i].exp_f2));
      @(posedge clock); #1;
      chk($sformatf("vec%0d_stall_cycles", i), 32'(cnt_a), 32'(tbl[i].exp_cnt));
      $display("vec %0d stall=%0b fwd1=%0d fwd2=%0d stall_cycles=%0d", i, stall_a, f1_a, f2_a, cnt_a);
    end

    // Random traffic on both builds against the reference model.
    ma = '{default: 0}; ma.n = 2;
    mb = '{default: 0}; mb.n = 4;
    for (int c = 0; c < 1500; c++) begin
      s = rand_vec(c < 2);
      drive_a(s); drive_b(s);
      #2;
      predict(ma, s, st_a, pf1, pf2);
      predict(mb, s, st_b, qf1, qf2);
      chk("rnd_a_stall", 32'(stall_a), 32'(st_a));
      chk("rnd_a_fwd1", 32'(f1_a), 32'(pf1));
      chk("rnd_a_fwd2", 32'(f2_a), 32'(pf2));
      chk("rnd_b_stall", 32'(stall_b), 32'(st_b));
      chk("rnd_b_fwd1", 32'(f1_b), 32'(qf1));
      chk("rnd_b_fwd2", 32'(f2_b), 32'(qf2));
      @(posedge clock); #1;
      ma = advance(ma, s, st_a);
      mb = advance(mb, s, st_b);
      chk("rnd_a_stall_cycles", 32'(cnt_a), 32'(ma.cnt));
      chk("rnd_b_stall_cycles", 32'(cnt_b), 32'(mb.cnt));
    end

    // Saturation: a self-dependent JR keeps re-stalling as its own write ages through.
    drive_a(idle_rst); drive_b(idle_rst);
    @(posedge clock); #1;
    ma = advance(ma, idle_rst, 1'b0);
    mb = advance(mb, idle_rst, 1'b0);
    s = mk(1,1,OP_JR, 0,0,7,1,1,7,0, 0,0,0,0);
    drive_a(s); drive_b(s);
    sat_cycles = 0;
    seen_34 = 1'b0;
    seen_35 = 1'b0;
    while (sat_cycles < 90000 && !(seen_35 && mb.cnt == 65535 && sat_cycles % 8 == 0)) begin
      #2;
      predict(ma, s, st_a, pf1, pf2);
      predict(mb, s, st_b, qf1, qf2);
      @(posedge clock); #1;
      ma = advance(ma, s, st_a);
      mb = advance(mb, s, st_b);
      sat_cycles++;
      if (!seen_34 && mb.cnt == 65534) begin
        seen_34 = 1'b1;
        chk("sat_b_at_65534", 32'(cnt_b), 32'(mb.cnt));
      end
      if (!seen_35 && mb.cnt == 65535) begin
        seen_35 = 1'b1;
        chk("sat_b_at_max", 32'(cnt_b), 32'h0000_FFFF);
      end
    end
    chk("sat_bound_reached", 32'(seen_35), 32'd1);
    repeat (12) begin
      #2;
      predict(mb, s, st_b, qf1, qf2);
      predict(ma, s, st_a, pf1, pf2);
      @(posedge clock); #1;
      ma = advance(ma, s, st_a);
      mb = advance(mb, s, st_b);
    end
    chk("sat_b_holds_max", 32'(cnt_b), 32'h0000_FFFF);
    chk("sat_a_long_count", 32'(cnt_a), 32'(ma.cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 4: register-address width.
REQ-002 Parameter OP_W, default 3: opcode width.
REQ-003 Parameter DEPTH, default 2: number of in-flight writer stages tracked, range 1..4.
REQ-004 Parameter JR_OPCODE, default all-ones of OP_W: jump-register opcode that needs its operand in decode.
REQ-005 Parameter LD_OPCODE, default 3'b010: load opcode whose result is available only after its first tracked stage.
REQ-006 clock  in  1  rising-edge clock; one clock only, named "clock".
REQ-007 reset  in  1  synchronous, active-low reset, named "reset".
REQ-008 issue_valid  in  1  a decode-stage instruction is present.
REQ-009 issue_opcode  in  OP_W  opcode of the decode instruction.
REQ-010 issue_src1 / issue_src2  in  ADDR_W each  source register addresses.
REQ-011 issue_src1_used / issue_src2_used  in  1 each  the source is actually read.
REQ-012 issue_wr_en  in  1  the decode instruction writes a register.
REQ-013 issue_dst  in  ADDR_W  destination register address.
REQ-014 flush  in  1  squash all tracked in-flight writers.
REQ-015 stall  out  1  hold decode and fetch this cycle.
REQ-016 fwd_sel1 / fwd_sel2  out  3 each  operand source: 0 = register file, k = tracked stage k-1.
REQ-017 stall_cycles  out  16  saturating count of cycles with stall=1.

Function
REQ-018 Scoreboard: DEPTH entries {valid, dst, is_load}; entry 0 is youngest.
REQ-019 Each rising edge, entry k shifts to entry k+1; the entry leaving entry DEPTH-1 is discarded.
REQ-020 Entry 0 loads {issue_valid & issue_wr_en & ~stall, issue_dst, opcode==LD_OPCODE}; a stall inserts a bubble (valid=0) into entry 0.
REQ-021 Match(s,k): src s used, issue_valid=1, entry k valid, entry k dst equal to src s address.
REQ-022 Load-use: stall=1 when any used source matches entry 0 and entry 0 is_load=1.
REQ-023 Jump-register: stall=1 when issue_opcode==JR_OPCODE and src2 matches any valid entry.
REQ-024 stall is combinational from inputs and scoreboard state; no other stall causes exist.
REQ-025 fwd_selN = k+1 for the youngest (lowest k) matching entry, else 0; forced 0 whenever stall=1.
REQ-026 Multiple matches resolve to the youngest entry only.
REQ-027 flush=1: stall and fwd_sel forced 0 that cycle; all entries invalid after the edge; flush dominates stall.
REQ-028 stall_cycles increments by 1 on each edge with stall=1 and saturates at 16'hFFFF.
REQ-029 issue_valid=0: stall=0, fwd_sel=0; the scoreboard still shifts.

Reset
REQ-030 With reset=0 at a rising edge, all entries are cleared to invalid and stall_cycles is set to 0.
REQ-031 While reset=0, stall=0 and fwd_sel1=fwd_sel2=0 combinationally.
REQ-032 Reset mid-stall discards the pending instruction state; there is no stall in the first cycle after release unless a new match arises.

Structure
REQ-033 Shared package holds the scoreboard entry typedef, default JR_OPCODE/LD_OPCODE constants, and the fwd_sel encoding constants.
REQ-034 One sub-module, hazard_match, compares one source against all entries and returns {match vector, youngest index}; it is instantiated twice.

Verification
REQ-035 Reset low 2 cycles, then release -> stall=0, fwd_sel=0, stall_cycles=0.
REQ-036 Issue ADD dst=5, then the next instruction reads src1=5 -> fwd_sel1=1 and stall=0; one cycle later (bubble between) -> fwd_sel1=2.
REQ-037 Issue LOAD dst=3, then an instruction reads src2=3 -> stall=1 for exactly 1 cycle, then fwd_sel2=2; stall_cycles=1.
REQ-038 JR (opcode 3'b111) with src2=7 while ADD dst=7 is in entry 0 (DEPTH=2) -> stall=1 for 2 cycles, then stall=0 with fwd_sel2=0.
REQ-039 Same LOAD-use hazard with flush=1 asserted in the stall cycle -> stall=0 that cycle, all entries invalid next cycle.
REQ-040 Force 65 540 consecutive stall cycles -> stall_cycles holds at 16'hFFFF; repeat the run with DEPTH=4 and ADDR_W=5.
